// File: rtl/full_connect2_if.sv
// Bus bundle for full_connect2: enable, activation/ROM/MultAdder inputs and
// the shared ROM/MultAdder buses plus the classification result.
// FC2_SCORE_OUT_EN adds the packed per-class score vector.
interface full_connect2_if;
    logic          ena;
    logic [2047:0] data_from_layer1;
    logic [2047:0] data_from_rom;
    logic [30:0]   data_from_MultAdder;
    logic [10:0]   addr_to_rom;
    logic [2047:0] opr1_to_MultAdder;
    logic [2047:0] opr2_to_MultAdder;
    logic [3:0]    digit;
    logic          done;
`ifdef FC2_SCORE_OUT_EN
    logic [309:0]  scores;
`endif

    modport slave (
        input  ena, data_from_layer1, data_from_rom, data_from_MultAdder,
        output addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder, digit, done
`ifdef FC2_SCORE_OUT_EN
        , output scores
`endif
    );

    modport master (
        output ena, data_from_layer1, data_from_rom, data_from_MultAdder,
        input  addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder, digit, done
`ifdef FC2_SCORE_OUT_EN
        , input scores
`endif
    );
endinterface

// File: rtl/full_connect2.sv
// Second fully-connected layer and arg-max classifier. Fetches the bias word,
// then for each of the 10 classes fetches a weight row, lets the shared
// MultAdder form the dot product, adds the scaled bias with saturation and
// tracks the best class. Shared buses are released (high-Z) while ena is low.
// Optional macro FC2_SCORE_OUT_EN exposes the 10 saturated scores.
module full_connect2 #(
    parameter logic [10:0] W_ADDR_BASE = 11'h500,
    parameter logic [10:0] BIAS_ADDR   = 11'h50A,
    parameter int          N_OUT       = 10
) (
    input logic           clk,
    input logic           iRst_n,
    full_connect2_if.slave bus
);

    localparam logic signed [30:0] SCORE_MAX = 31'sh3FFFFFFF;
    localparam logic signed [30:0] SCORE_MIN = 31'sh40000000;

    typedef enum logic [3:0] {
        ASK_B, WAIT_B, GET_B, ASK_W, WAIT_W, GET_W, MAC, STORE, FIN
    } state_t;

    state_t state, next_state;

    logic [10:0]        addr_reg;
    logic [2047:0]      opr1_reg;
    logic [2047:0]      opr2_reg;
    logic               bus_en;
    logic [159:0]       bias_word;
    logic [3:0]         row;
    logic signed [30:0] score;
    logic signed [30:0] max_score;
    logic [3:0]         max_idx;
    logic [3:0]         digit_reg;
    logic               done_reg;
`ifdef FC2_SCORE_OUT_EN
    logic [309:0]       scores_reg;
`endif

    logic               load_addr;
    logic [10:0]        ask_addr;
    logic               load_bias;
    logic               load_opr;
    logic               calc_score;
    logic               store_row;
    logic               finish;

    logic [15:0]        bias_sel;
    logic signed [30:0] bias_ext;
    logic signed [31:0] sum_wide;
    logic signed [30:0] sat_score;

    // State register: a low enable wins over reset, both restart at ASK_B.
    always_ff @(posedge clk) begin
        if (!bus.ena) begin
            state <= ASK_B;
        end else if (!iRst_n) begin
            state <= ASK_B;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing through the bias fetch and the ten row passes.
    always_comb begin
        next_state = state;
        case (state)
            ASK_B:  next_state = WAIT_B;
            WAIT_B: next_state = GET_B;
            GET_B:  next_state = ASK_W;
            ASK_W:  next_state = WAIT_W;
            WAIT_W: next_state = GET_W;
            GET_W:  next_state = MAC;
            MAC:    next_state = STORE;
            STORE:  next_state = (row == 4'(N_OUT - 1)) ? FIN : ASK_W;
            FIN:    next_state = FIN;
            default: next_state = ASK_B;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        load_addr  = 1'b0;
        ask_addr   = '0;
        load_bias  = 1'b0;
        load_opr   = 1'b0;
        calc_score = 1'b0;
        store_row  = 1'b0;
        finish     = 1'b0;
        case (state)
            ASK_B: begin
                load_addr = 1'b1;
                ask_addr  = BIAS_ADDR;
            end
            GET_B: load_bias = 1'b1;
            ASK_W: begin
                load_addr = 1'b1;
                ask_addr  = W_ADDR_BASE + 11'(row);
            end
            GET_W: load_opr   = 1'b1;
            MAC:   calc_score = 1'b1;
            STORE: store_row  = 1'b1;
            FIN:   finish     = 1'b1;
            default: ;
        endcase
    end

    // Bias is placed at bit 10 of the 31-bit score; the sum is widened by one
    // bit so overflow can be detected and clamped to the 31-bit signed range.
    always_comb begin
        bias_sel = bias_word[int'(row)*16 +: 16];
        bias_ext = {{5{bias_sel[15]}}, bias_sel, 10'b0};
        sum_wide = $signed({bus.data_from_MultAdder[30], bus.data_from_MultAdder})
                 + $signed({bias_ext[30], bias_ext});
        if (sum_wide > 32'sh3FFFFFFF) begin
            sat_score = SCORE_MAX;
        end else if (sum_wide < 32'shC0000000) begin
            sat_score = SCORE_MIN;
        end else begin
            sat_score = sum_wide[30:0];
        end
    end

    // Datapath registers; disable keeps digit but releases the buses,
    // reset clears everything and drives the buses with zero.
    always_ff @(posedge clk) begin
        if (!bus.ena) begin
            done_reg <= 1'b0;
            row      <= '0;
            bus_en   <= 1'b0;
        end else if (!iRst_n) begin
            done_reg   <= 1'b0;
            digit_reg  <= '0;
            row        <= '0;
            max_score  <= '0;
            max_idx    <= '0;
            score      <= '0;
            bias_word  <= '0;
            addr_reg   <= '0;
            opr1_reg   <= '0;
            opr2_reg   <= '0;
            bus_en     <= 1'b1;
`ifdef FC2_SCORE_OUT_EN
            scores_reg <= '0;
`endif
        end else begin
            bus_en <= 1'b1;
            if (load_addr) begin
                addr_reg <= ask_addr;
            end
            if (load_bias) begin
                bias_word <= bus.data_from_rom[159:0];
                row       <= '0;
                max_score <= SCORE_MIN;
                max_idx   <= '0;
            end
            if (load_opr) begin
                opr1_reg <= bus.data_from_layer1;
                opr2_reg <= bus.data_from_rom;
            end
            if (calc_score) begin
                score <= sat_score;
            end
            if (store_row) begin
                if (score > max_score) begin
                    max_score <= score;
                    max_idx   <= row;
                end
`ifdef FC2_SCORE_OUT_EN
                scores_reg[int'(row)*31 +: 31] <= score;
`endif
                row <= row + 4'd1;
            end
            if (finish) begin
                done_reg  <= 1'b1;
                digit_reg <= max_idx;
            end
        end
    end

    assign bus.addr_to_rom       = bus_en ? addr_reg : {11{1'bz}};
    assign bus.opr1_to_MultAdder = bus_en ? opr1_reg : {2048{1'bz}};
    assign bus.opr2_to_MultAdder = bus_en ? opr2_reg : {2048{1'bz}};
    assign bus.digit             = digit_reg;
    assign bus.done              = done_reg;
`ifdef FC2_SCORE_OUT_EN
    assign bus.scores            = scores_reg;
`endif

endmodule

// File: tb/tb_full_connect2.sv
// Testbench for full_connect2: stub ROM with registered read, behavioural
// MultAdder, and an arg-max reference model computed from plain arithmetic.
module tb_full_connect2;

    logic clk = 1'b0;
    logic iRst_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0]        act  [128];
    logic signed [15:0] wgt  [10][128];
    logic signed [15:0] bias [10];
    longint             exp_score [10];
    int                 exp_digit;
    int                 mult_acc;

    always #5 clk = ~clk;

    full_connect2_if bus();

    full_connect2 dut (
        .clk    (clk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    // Stub ROM image: bias word and weight rows built from the test arrays.
    function automatic logic [2047:0] rom_word(input logic [10:0] a);
        logic [2047:0] v;
        v = '0;
        if (a == 11'h50A) begin
            for (int i = 0; i < 10; i++) v[16*i +: 16] = bias[i];
        end else if (a >= 11'h500 && a <= 11'h509) begin
            for (int i = 0; i < 128; i++) v[16*i +: 16] = wgt[int'(a - 11'h500)][i];
        end
        return v;
    endfunction

    // ROM read register.
    always @(posedge clk) bus.data_from_rom <= rom_word(bus.addr_to_rom);

    // Behavioural MultAdder: signed sum of the 128 lane products.
    always_comb begin
        mult_acc = 0;
        for (int i = 0; i < 128; i++)
            mult_acc += $signed(bus.opr1_to_MultAdder[16*i +: 16])
                      * $signed(bus.opr2_to_MultAdder[16*i +: 16]);
        bus.data_from_MultAdder = mult_acc[30:0];
    end

    task automatic check_output(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 128; i++) act[i] = '0;
        for (int r = 0; r < 10; r++) begin
            bias[r] = '0;
            for (int i = 0; i < 128; i++) wgt[r][i] = '0;
        end
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < 128; i++) bus.data_from_layer1[16*i +: 16] = act[i];
    endtask

    // Reference: dot product plus bias*1024, clamp, strict arg-max.
    task automatic compute_expected();
        longint best;
        best = -(64'sd1 << 30);
        exp_digit = 0;
        for (int r = 0; r < 10; r++) begin
            longint s;
            s = 0;
            for (int i = 0; i < 128; i++) s += longint'(act[i]) * longint'(wgt[r][i]);
            s += longint'(bias[r]) * 1024;
            if (s > 1073741823) s = 1073741823;
            if (s < -1073741824) s = -1073741824;
            exp_score[r] = s;
            if (s > best) begin
                best = s;
                exp_digit = r;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int n);
        check_output({tag, "_latency"}, n, 54);
        check_output({tag, "_digit"}, bus.digit, exp_digit);
`ifdef FC2_SCORE_OUT_EN
        for (int r = 0; r < 10; r++)
            check_output($sformatf("%s_score%0d", tag, r),
                         longint'($signed(bus.scores[31*r +: 31])), exp_score[r]);
`endif
    endtask

    task automatic run_inference(input string tag);
        int n;
        apply_stimulus();
        compute_expected();
        bus.ena = 1'b1;
        iRst_n  = 1'b0;
        @(posedge clk);
        #1;
        iRst_n = 1'b1;
        wait_done(n);
        check_result(tag, n);
    endtask

    initial begin
        int n;
        bus.ena = 1'b1;
        iRst_n  = 1'b0;
        clear_all();
        apply_stimulus();
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_done", bus.done, 0);
        check_output("rst_digit", bus.digit, 0);
        check_output("rst_addr", bus.addr_to_rom, 0);
        checks++;
        assert (bus.opr1_to_MultAdder === '0) else begin
            errors++;
            $error("[TB] FAIL rst_opr1 observed=%0h expected=0", bus.opr1_to_MultAdder[31:0]);
        end
        checks++;
        assert (bus.opr2_to_MultAdder === '0) else begin
            errors++;
            $error("[TB] FAIL rst_opr2 observed=%0h expected=0", bus.opr2_to_MultAdder[31:0]);
        end

        $display("[TB] bias-only class 7");
        clear_all();
        bias[7] = 16'sd5;
        run_inference("bias7");

        $display("[TB] tie between rows 2 and 6");
        clear_all();
        act[0] = 16'd1;
        wgt[2][0] = 16'sd100;
        wgt[6][0] = 16'sd100;
        run_inference("tie");

        $display("[TB] all-negative scores");
        clear_all();
        act[0] = 16'd1;
        for (int r = 0; r < 9; r++) wgt[r][0] = -16'sd1000;
        wgt[9][0] = -16'sd5;
        run_inference("neg");

        $display("[TB] saturation on row 4");
        clear_all();
        act[0] = 16'd32767;
        act[1] = 16'd2;
        wgt[4][0] = 16'sd32767;
        wgt[4][1] = 16'sd32767;
        bias[4] = 16'sh7FFF;
        run_inference("sat");

        $display("[TB] random rows");
        for (int t = 0; t < 4; t++) begin
            clear_all();
            for (int i = 0; i < 128; i++) act[i] = 16'($urandom_range(0, 255));
            for (int r = 0; r < 10; r++) begin
                bias[r] = 16'(int'($urandom_range(0, 600)) - 300);
                for (int i = 0; i < 128; i++) wgt[r][i] = 16'(int'($urandom_range(0, 127)) - 64);
            end
            run_inference($sformatf("rand%0d", t));
        end

        $display("[TB] reset abort at edge 30");
        apply_stimulus();
        compute_expected();
        iRst_n = 1'b0;
        @(posedge clk);
        #1;
        iRst_n = 1'b1;
        repeat (29) @(posedge clk);
        #1;
        iRst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_done_low", bus.done, 0);
        iRst_n = 1'b1;
        wait_done(n);
        check_result("abort", n);

        $display("[TB] enable drop after completion and mid-run");
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check_output("off_done", bus.done, 0);
        check_output("off_digit_held", bus.digit, exp_digit);
        checks++;
        assert (bus.addr_to_rom === {11{1'bz}}) else begin
            errors++;
            $error("[TB] FAIL off_addr observed=%0h expected=z", bus.addr_to_rom);
        end
        bus.ena = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid_off_done", bus.done, 0);
        checks++;
        assert (bus.addr_to_rom === {11{1'bz}}) else begin
            errors++;
            $error("[TB] FAIL mid_off_addr observed=%0h expected=z", bus.addr_to_rom);
        end
        checks++;
        assert (bus.opr1_to_MultAdder === {2048{1'bz}}) else begin
            errors++;
            $error("[TB] FAIL mid_off_opr1 observed=%0h expected=z", bus.opr1_to_MultAdder[31:0]);
        end
        checks++;
        assert (bus.opr2_to_MultAdder === {2048{1'bz}}) else begin
            errors++;
            $error("[TB] FAIL mid_off_opr2 observed=%0h expected=z", bus.opr2_to_MultAdder[31:0]);
        end
        bus.ena = 1'b1;
        wait_done(n);
        check_result("reenable", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_connect2.md
# full_connect2

Second fully-connected layer and classifier of the digit-recognition datapath. Consumes the 128 ReLU'd 16-bit activations produced by `full_connect1`, computes 10 class scores as weight-row dot products plus bias, and reports the arg-max class as the recognised digit. It shares the weight/bias ROM and the 128-lane `MultAdder` with the other layers, and drives their buses only while enabled.

## Interface
Parameters:
- `W_ADDR_BASE`, default 11'h500: ROM address of weight row 0. Row r is at `W_ADDR_BASE + r`, one 128×16 word per row, and lane i multiplies activation i.
- `BIAS_ADDR`, default 11'h50A: ROM word holding the 10 biases. Bias r is in bits `[16r+15 -: 16]`.
- `N_OUT`, default 10: number of classes. The RTL is written for 10; other values are unsupported.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `iRst_n`  in  1: reset, synchronous and active-low.
- `ena`  in  1: block enable; has priority over reset.
- `data_from_layer1`  in  2048: 128 activations, 16-bit each, from `full_connect1`. Held stable by the sequencer while `ena`=1.
- `data_from_rom`  in  2048: ROM read word.
- `data_from_MultAdder`  in  31: signed sum of the 128 lane products.
- `addr_to_rom`  out  11: ROM address.
- `opr1_to_MultAdder`  out  2048: activation operand.
- `opr2_to_MultAdder`  out  2048: weight operand.
- `digit`  out  4: recognised class, 0..9.
- `done`  out  1: result valid. Stays high until reset or `ena` falls.

## Operation
- States: ASK_B → WAIT_B → GET_B → {ASK_W → WAIT_W → GET_W → MAC → STORE} ×10 → FIN.
- ASK_B: drive `addr_to_rom`=`BIAS_ADDR`.
- WAIT_B: idle one cycle.
- GET_B: latch the bias word; clear row counter r=0; set max_score=−2^30 and max_idx=0.
- ASK_W: drive `addr_to_rom`=`W_ADDR_BASE`+r.
- WAIT_W: idle one cycle.
- GET_W: drive `opr1`=`data_from_layer1` and `opr2`=`data_from_rom`.
- MAC: score = sat31(`data_from_MultAdder` + bias_ext), where:
  - bias_ext = {5×bias[15], bias[15:0], 10'b0}, sign-extended to 31 bits;
  - the sum is computed at 32 bits and clamped to [−2^30, 2^30−1].
- STORE:
  - if score > max_score (signed, strict), set max_score=score and max_idx=r; ties keep the lower index;
  - r=r+1;
  - go to FIN if r==10, else ASK_W.
- FIN: `digit`=max_idx, `done`=1; remain in FIN.
- ROM contract: data is valid two edges after the address is driven, so it is sampled in GET_*. There is no ready polling.
- MultAdder contract: combinational; its result is sampled one edge after the operands are driven (in MAC).

Reset and enable:
- `ena`=0, checked first on each edge:
  - go to ASK_B; `done`=0; r=0;
  - `addr_to_rom`, `opr1_to_MultAdder` and `opr2_to_MultAdder` go high-Z (shared buses);
  - `digit` is held.
- `ena`=1 with `iRst_n`=0:
  - go to ASK_B; `done`=0; `digit`=0; r=0; max registers cleared;
  - buses are driven with 0.
- Reset or `ena` drop mid-operation aborts the computation with no partial result.
- Reset value of every output: `done`=0, `digit`=0, `addr_to_rom`=0, `opr1_to_MultAdder`=0, `opr2_to_MultAdder`=0.

## Timing
- Latency:
  - edges 1–3 are ASK_B, WAIT_B, GET_B;
  - each row takes 5 edges, so the 10 rows cover edges 4–53;
  - `done` rises on edge 54 after the first edge with `iRst_n`=1 and `ena`=1.
- `digit` and `done` change on the same edge.
- Operand buses hold their values from GET_W until the next GET_W.
- `addr_to_rom` holds until the next ASK state.

## Configuration
- `FC2_SCORE_OUT_EN` defined:
  - adds output port `scores` (310 bits; score r in `[31r+30 -: 31]`), reset to 0;
  - score r is written in STORE of row r and held after `done`.
- Not defined: the port is absent and per-row scores are not stored; only max_score and max_idx exist.
- Latency and `digit` are identical in both builds.

## Test plan
- Bench model: a stub ROM with 2-cycle read latency and a behavioural MultAdder.
  - Stimulus: activations all 0, biases {0,…,0,5 at class 7,0,0}.
  - Required: `digit`=7, with `done` high on edge 54.
- Tie:
  - Stimulus: MultAdder returns 100 for rows 2 and 6, 0 otherwise; biases 0.
  - Required: `digit`=2.
- All-negative scores:
  - Stimulus: every row sums to −1000 except row 9 at −5.
  - Required: `digit`=9.
- Saturation, with `FC2_SCORE_OUT_EN` defined:
  - Stimulus: row 4 MultAdder result 2^30−1 and bias 16'h7FFF.
  - Required: score 4 = 2^30−1 and `digit`=4.
- Abort:
  - Stimulus: drop `iRst_n` at edge 30 for one cycle, then release.
  - Required: `done` stays 0 and rises 54 edges after release with the correct `digit`.
- Bus release:
  - Stimulus: `ena`=0 mid-run.
  - Required: `addr_to_rom`, `opr1_to_MultAdder` and `opr2_to_MultAdder` are Z on the next edge, and `done`=0.
